// File: rtl/dm_sba_ctrl_pkg.sv
// Shared types and constants for the system bus access engine of the debug module.
// Also holds the size and alignment checks applied to every bus access.
package dm_sba_ctrl_pkg;

   typedef enum logic [1:0] {
      Idle     = 2'd0,
      Req      = 2'd1,
      WaitResp = 2'd2
   } sba_state_e;

   localparam logic [2:0] SbErrNone    = 3'd0;
   localparam logic [2:0] SbErrTimeout = 3'd1;
   localparam logic [2:0] SbErrBadAddr = 3'd2;
   localparam logic [2:0] SbErrAlign   = 3'd3;
   localparam logic [2:0] SbErrSize    = 3'd4;
   localparam logic [2:0] SbErrOther   = 3'd7;

   localparam logic [2:0] SbAccess8  = 3'd0;
   localparam logic [2:0] SbAccess16 = 3'd1;
   localparam logic [2:0] SbAccess32 = 3'd2;
   localparam logic [2:0] SbAccess64 = 3'd3;

   // The access is wider than the bus when its byte count exceeds the bus byte count.
   function automatic logic sb_size_too_big(input logic [2:0] access, input int unsigned bus_bytes);
      return (32'd1 << access) > bus_bytes;
   endfunction

   function automatic logic sb_misaligned(input logic [2:0] addr_lo, input logic [2:0] access);
      logic mis;
      case (access)
         SbAccess8:  mis = 1'b0;
         SbAccess16: mis = addr_lo[0];
         SbAccess32: mis = |addr_lo[1:0];
         default:    mis = |addr_lo;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dm_sba_ctrl_if.sv
// Single-beat system bus master port used by the SBA engine.
interface dm_sba_ctrl_if #(
   parameter int unsigned BusWidth = 32
) ();
   // req and all request fields stay stable until the cycle gnt is high; the
   // transfer is accepted on that clock edge. Exactly one rvalid follows each
   // accepted request, and err only has meaning while rvalid is high.
   logic                  req;
   logic [BusWidth-1:0]   addr;
   logic                  we;
   logic [BusWidth-1:0]   wdata;
   logic [BusWidth/8-1:0] be;
   logic                  gnt;
   logic                  rvalid;
   logic [BusWidth-1:0]   rdata;
   logic                  err;

   modport master (
      output req, addr, we, wdata, be,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, addr, we, wdata, be,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/dm_sba_lanes.sv
// Byte-lane steering: builds byte enables and shifted write data for a request,
// and extracts zero-extended read data from the response word.
module dm_sba_lanes
   import dm_sba_ctrl_pkg::*;
#(
   parameter int unsigned BusWidth = 32
) (
   input  logic [$clog2(BusWidth/8)-1:0] wr_off_i,
   input  logic [2:0]                    wr_size_i,
   input  logic [BusWidth-1:0]           wdata_i,
   input  logic [$clog2(BusWidth/8)-1:0] rd_off_i,
   input  logic [2:0]                    rd_size_i,
   input  logic [BusWidth-1:0]           rdata_i,
   output logic [BusWidth/8-1:0]         be_o,
   output logic [BusWidth-1:0]           wdata_o,
   output logic [BusWidth-1:0]           rdata_o
);
   localparam int unsigned NumBytes = BusWidth / 8;

   logic [NumBytes-1:0] be_base;
   logic [BusWidth-1:0] rd_mask;
   logic [BusWidth-1:0] rd_shifted;

   always_comb begin
      be_base = '1;
      case (wr_size_i)
         SbAccess8:  be_base = NumBytes'(8'h01);
         SbAccess16: be_base = NumBytes'(8'h03);
         SbAccess32: be_base = NumBytes'(8'h0F);
         default:    be_base = '1;
      endcase
      be_o    = be_base << wr_off_i;
      wdata_o = wdata_i << {wr_off_i, 3'b000};
   end

   always_comb begin
      rd_mask = '1;
      case (rd_size_i)
         SbAccess8:  rd_mask = BusWidth'(64'h0000_0000_0000_00FF);
         SbAccess16: rd_mask = BusWidth'(64'h0000_0000_0000_FFFF);
         SbAccess32: rd_mask = BusWidth'(64'h0000_0000_FFFF_FFFF);
         default:    rd_mask = '1;
      endcase
      rd_shifted = rdata_i >> {rd_off_i, 3'b000};
      rdata_o    = rd_shifted & rd_mask;
   end
endmodule

// File: rtl/dm_sba_ctrl.sv
// System bus access engine: owns sbaddress/sbdata and SBA status, and turns
// DMI register accesses into single-beat transactions on the bus master port.
module dm_sba_ctrl
   import dm_sba_ctrl_pkg::*;
#(
   parameter int unsigned BusWidth = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                dmactive_i,
   input  logic [BusWidth-1:0] sbaddress_i,
   input  logic                sbaddress_we_i,
   input  logic [BusWidth-1:0] sbdata_i,
   input  logic                sbdata_we_i,
   input  logic                sbdata_re_i,
   input  logic                sbreadonaddr_i,
   input  logic                sbreadondata_i,
   input  logic                sbautoincrement_i,
   input  logic [2:0]          sbaccess_i,
   input  logic                sberror_clr_i,
   input  logic                sbbusyerror_clr_i,
   output logic [BusWidth-1:0] sbaddress_o,
   output logic [BusWidth-1:0] sbdata_o,
   output logic                sbbusy_o,
   output logic [2:0]          sberror_o,
   output logic                sbbusyerror_o,
   output sba_state_e          state_o,
   dm_sba_ctrl_if.master       bus
);
   localparam int unsigned NumBytes = BusWidth / 8;
   localparam int unsigned OffW     = $clog2(NumBytes);

   sba_state_e          state_q, state_d;
   logic [BusWidth-1:0] sbaddress_q, sbaddress_d;
   logic [BusWidth-1:0] sbdata_q, sbdata_d;
   logic [2:0]          sberror_q, sberror_d;
   logic                sbbusyerror_q, sbbusyerror_d;
   logic                req_q, req_d;
   logic [BusWidth-1:0] addr_q, addr_d;
   logic                we_q, we_d;
   logic [BusWidth-1:0] wdata_q, wdata_d;
   logic [NumBytes-1:0] be_q, be_d;
   logic [2:0]          access_q, access_d;
   logic                drain_q, drain_d;

   logic [BusWidth-1:0] eff_addr, eff_data;
   logic [NumBytes-1:0] lane_be;
   logic [BusWidth-1:0] lane_wdata, lane_rdata;
   logic                wr_trig, rd_trig, dmi_access, err_block;

   // A triggering write must use the value being written this cycle, not the old register.
   assign eff_addr = sbaddress_we_i ? sbaddress_i : sbaddress_q;
   assign eff_data = sbdata_we_i ? sbdata_i : sbdata_q;

   dm_sba_lanes #(.BusWidth(BusWidth)) u_lanes (
      .wr_off_i  (eff_addr[OffW-1:0]),
      .wr_size_i (sbaccess_i),
      .wdata_i   (eff_data),
      .rd_off_i  (sbaddress_q[OffW-1:0]),
      .rd_size_i (access_q),
      .rdata_i   (bus.rdata),
      .be_o      (lane_be),
      .wdata_o   (lane_wdata),
      .rdata_o   (lane_rdata)
   );

   assign wr_trig    = sbdata_we_i;
   assign rd_trig    = (sbaddress_we_i & sbreadonaddr_i) | (sbdata_re_i & sbreadondata_i);
   assign dmi_access = sbaddress_we_i | sbdata_we_i | sbdata_re_i;
   assign err_block  = (sberror_q != SbErrNone) | sbbusyerror_q;

   always_comb begin
      state_d       = state_q;
      sbaddress_d   = sbaddress_q;
      sbdata_d      = sbdata_q;
      sberror_d     = sberror_q;
      sbbusyerror_d = sbbusyerror_q;
      req_d         = req_q;
      addr_d        = addr_q;
      we_d          = we_q;
      wdata_d       = wdata_q;
      be_d          = be_q;
      access_d      = access_q;
      drain_d       = drain_q;

      // Clears are applied first so that a set in the same cycle wins.
      if (sberror_clr_i)     sberror_d     = SbErrNone;
      if (sbbusyerror_clr_i) sbbusyerror_d = 1'b0;

      unique case (state_q)
         Idle: begin
            if (sbaddress_we_i) sbaddress_d = sbaddress_i;
            if (sbdata_we_i)    sbdata_d    = sbdata_i;
            if ((wr_trig || rd_trig) && !err_block) begin
               if (sb_size_too_big(sbaccess_i, NumBytes)) begin
                  sberror_d = SbErrSize;
               end else if (sb_misaligned(eff_addr[2:0], sbaccess_i)) begin
                  sberror_d = SbErrAlign;
               end else begin
                  state_d  = Req;
                  req_d    = 1'b1;
                  addr_d   = {eff_addr[BusWidth-1:OffW], {OffW{1'b0}}};
                  we_d     = wr_trig;
                  wdata_d  = lane_wdata;
                  be_d     = lane_be;
                  access_d = sbaccess_i;
               end
            end
         end
         Req: begin
            if (dmi_access) sbbusyerror_d = 1'b1;
            if (bus.gnt) begin
               req_d   = 1'b0;
               state_d = WaitResp;
            end
         end
         WaitResp: begin
            if (dmi_access && !drain_q) sbbusyerror_d = 1'b1;
            if (bus.rvalid) begin
               state_d = Idle;
               drain_d = 1'b0;
               if (!drain_q) begin
                  if (bus.err) begin
                     sberror_d = SbErrBadAddr;
                  end else begin
                     if (!we_q) sbdata_d = lane_rdata;
                     if (sbautoincrement_i) sbaddress_d = sbaddress_q + (BusWidth'(1) << access_q);
                  end
               end
            end
         end
         default: state_d = Idle;
      endcase

      // Deactivation clears everything but must still absorb an outstanding response.
      if (!dmactive_i) begin
         sbaddress_d   = '0;
         sbdata_d      = '0;
         sberror_d     = SbErrNone;
         sbbusyerror_d = 1'b0;
         req_d         = 1'b0;
         addr_d        = '0;
         we_d          = 1'b0;
         wdata_d       = '0;
         be_d          = '0;
         access_d      = '0;
         if (state_q == WaitResp && !bus.rvalid) begin
            state_d = WaitResp;
            drain_d = 1'b1;
         end else begin
            state_d = Idle;
            drain_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= Idle;
         sbaddress_q   <= '0;
         sbdata_q      <= '0;
         sberror_q     <= SbErrNone;
         sbbusyerror_q <= 1'b0;
         req_q         <= 1'b0;
         addr_q        <= '0;
         we_q          <= 1'b0;
         wdata_q       <= '0;
         be_q          <= '0;
         access_q      <= '0;
         drain_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         sbaddress_q   <= sbaddress_d;
         sbdata_q      <= sbdata_d;
         sberror_q     <= sberror_d;
         sbbusyerror_q <= sbbusyerror_d;
         req_q         <= req_d;
         addr_q        <= addr_d;
         we_q          <= we_d;
         wdata_q       <= wdata_d;
         be_q          <= be_d;
         access_q      <= access_d;
         drain_q       <= drain_d;
      end
   end

   assign sbaddress_o   = sbaddress_q;
   assign sbdata_o      = sbdata_q;
   assign sbbusy_o      = (state_q != Idle) && !drain_q;
   assign sberror_o     = sberror_q;
   assign sbbusyerror_o = sbbusyerror_q;
   assign state_o       = state_q;

   assign bus.req   = req_q;
   assign bus.addr  = addr_q;
   assign bus.we    = we_q;
   assign bus.wdata = wdata_q;
   assign bus.be    = be_q;
endmodule
